// File: rtl/result_capture_fifo.sv
// Parity-protected first-word-fall-through FIFO capturing adder-chain sums with
// their alarm tag, plus sticky/saturating alarm accounting.
module result_capture_fifo #(
  parameter int WORD_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WORD_WIDTH-1:0]     sum_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      alarm_in,
  output logic [WORD_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_par_err,
  output logic                      out_alarm,
  input  logic                      clr_alarm,
  output logic                      alarm_sticky,
  output logic [CNT_W-1:0]          alarm_count,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WORD_WIDTH-1:0] mem_word;
  logic [DEPTH-1:0]                 mem_par;
  logic [DEPTH-1:0]                 mem_tag;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          full, empty, wr_fire, rd_fire;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_fire = in_valid & ~full;
  assign rd_fire = out_ready & ~empty;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign level     = wr_ptr - rd_ptr;

  // Head decode is gated so an empty FIFO never exposes stale storage.
  assign out_data    = empty ? '0   : mem_word[rd_idx];
  assign out_par_err = empty ? 1'b0 : (^mem_word[rd_idx]) ^ mem_par[rd_idx];
  assign out_alarm   = empty ? 1'b0 : mem_tag[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_word[wr_idx] <= sum_in;
      mem_par[wr_idx]  <= ^sum_in;
      mem_tag[wr_idx]  <= alarm_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_sticky <= 1'b0;
      alarm_count  <= '0;
    end else if (clr_alarm) begin
      // A same-cycle alarm survives the clear as the first new event.
      alarm_sticky <= alarm_in;
      alarm_count  <= alarm_in ? CNT_W'(1) : '0;
    end else if (alarm_in) begin
      alarm_sticky <= 1'b1;
      if (alarm_count != {CNT_W{1'b1}}) alarm_count <= alarm_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_result_capture_fifo.sv
// Scoreboard bench for result_capture_fifo: a queue model of the FIFO contents
// and alarm counters, compared against the DUT one cycle at a time.
module tb_result_capture_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sum_in = '0;
  logic       in_valid = 1'b0, alarm_in = 1'b0, out_ready = 1'b0, clr_alarm = 1'b0;
  logic       in_ready, out_valid, out_par_err, out_alarm, alarm_sticky;
  logic [3:0] out_data;
  logic [7:0] alarm_count;
  logic [2:0] level;
  logic       d2_in_ready, d2_out_valid, d2_out_par_err, d2_out_alarm, d2_alarm_sticky;
  logic [3:0] d2_out_data;
  logic [1:0] d2_alarm_count;
  logic [2:0] d2_level;

  always #5 clk = ~clk;

  result_capture_fifo #(.WORD_WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid), .in_ready(in_ready),
    .alarm_in(alarm_in), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_par_err(out_par_err), .out_alarm(out_alarm), .clr_alarm(clr_alarm),
    .alarm_sticky(alarm_sticky), .alarm_count(alarm_count), .level(level));

  result_capture_fifo #(.WORD_WIDTH(4), .DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid), .in_ready(d2_in_ready),
    .alarm_in(alarm_in), .out_data(d2_out_data), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_par_err(d2_out_par_err), .out_alarm(d2_out_alarm), .clr_alarm(clr_alarm),
    .alarm_sticky(d2_alarm_sticky), .alarm_count(d2_alarm_count), .level(d2_level));

  typedef struct {logic [3:0] word; logic tag;} exp_t;
  exp_t       q[$];
  logic [7:0] exp_cnt;
  logic [1:0] exp_cnt2;
  logic       exp_sticky;
  logic       last_wr;
  int         vectors = 0, miscompares = 0;

  // Advance one clock and update the model using the inputs held across the edge.
  task automatic tick();
    logic wr, rd;
    exp_t e;
    wr = in_valid && (q.size() < 4);
    rd = out_ready && (q.size() > 0);
    e.word = sum_in;
    e.tag  = alarm_in;
    @(posedge clk);
    #1;
    last_wr = wr;
    if (rst_n) begin
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(e);
      if (clr_alarm) begin
        exp_cnt    = alarm_in ? 8'd1 : 8'd0;
        exp_cnt2   = alarm_in ? 2'd1 : 2'd0;
        exp_sticky = alarm_in;
      end else if (alarm_in) begin
        exp_sticky = 1'b1;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_cnt = '0; exp_cnt2 = '0; exp_sticky = 1'b0;
  endtask

  task automatic apply_reset();
    in_valid = 0; out_ready = 0; alarm_in = 0; clr_alarm = 0;
    rst_n = 0; model_reset();
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", level); end
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_flags got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
    vectors++; if ({out_data, out_par_err, out_alarm} !== 6'd0) begin miscompares++; $display("FAIL reset_outs got %h/%b/%b exp 0", out_data, out_par_err, out_alarm); end
    vectors++; if (alarm_count !== 8'd0 || alarm_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_alarm got %0d/%b exp 0/0", alarm_count, alarm_sticky); end
    for (int i = 0; i < 3; i++) begin in_valid = 1; sum_in = 4'(i + 9); tick(); end
    in_valid = 0;
    vectors++; if (level !== 3'd3) begin miscompares++; $display("FAIL pre_reset_level got %0d exp 3", level); end
    #2 rst_n = 0; model_reset();
    #1;
    vectors++; if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'd0) begin
      miscompares++; $display("FAIL midreset got lvl=%0d vld=%b rdy=%b data=%h exp 0/0/1/0", level, out_valid, in_ready, out_data); end
    tick();
    rst_n = 1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_fill_drain();
    logic [3:0] words [4];
    words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'hA; words[3] = 4'hF;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; sum_in = words[i]; tick();
      if (i == 0) begin
        vectors++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin miscompares++; $display("FAIL fwft got vld=%b data=%h exp 1/3", out_valid, out_data); end
      end
    end
    vectors++; if (in_ready !== 1'b0 || level !== 3'd4) begin miscompares++; $display("FAIL full got rdy=%b lvl=%0d exp 0/4", in_ready, level); end
    sum_in = 4'h1; tick();
    in_valid = 0;
    vectors++; if (level !== 3'd4 || out_data !== 4'h3) begin miscompares++; $display("FAIL fifth_write got lvl=%0d head=%h exp 4/3", level, out_data); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_data !== q[0].word || out_par_err !== 1'b0 || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL drain%0d got %h/%b/%b exp %h/0/1", i, out_data, out_par_err, out_valid, q[0].word); end
      tick();
    end
    out_ready = 0;
    vectors++; if (out_valid !== 1'b0 || q.size() != 0) begin miscompares++; $display("FAIL drained got vld=%b exp 0", out_valid); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) begin in_valid = 1; sum_in = 4'(i + 4'hB); tick(); end
    in_valid = 1; sum_in = 4'h2; out_ready = 1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL simul_rdy got %b exp 0", in_ready); end
    tick();
    vectors++; if (level !== 3'(q.size()) || level !== 3'd3) begin miscompares++; $display("FAIL simul_read got lvl=%0d exp 3", level); end
    out_ready = 0;
    tick();
    in_valid = 0;
    vectors++; if (level !== 3'd4 || !last_wr) begin miscompares++; $display("FAIL held_write got lvl=%0d exp 4", level); end
    for (int pass = 0; pass < 3; pass++) begin
      out_ready = 1;
      while (q.size() > 0) begin
        vectors++; if (out_data !== q[0].word) begin miscompares++; $display("FAIL pass%0d_data got %h exp %h", pass, out_data, q[0].word); end
        tick();
      end
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin in_valid = 1; sum_in = 4'($urandom); tick(); end
      in_valid = 0;
    end
    // Random handshake traffic with the source holding each word until accepted.
    in_valid = 1; sum_in = 4'($urandom);
    for (int c = 0; c < 60; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      vectors++; if (out_valid !== (q.size() != 0) || level !== 3'(q.size())) begin
        miscompares++; $display("FAIL stream_lvl got vld=%b lvl=%0d exp lvl %0d", out_valid, level, q.size()); end
      if (q.size() != 0) begin
        vectors++; if (out_data !== q[0].word) begin miscompares++; $display("FAIL stream_data got %h exp %h", out_data, q[0].word); end
      end
      tick();
      if (last_wr) begin in_valid = 1'($urandom_range(0, 1)); sum_in = 4'($urandom); end
      else if (!in_valid) begin in_valid = 1'($urandom_range(0, 1)); sum_in = 4'($urandom); end
    end
    in_valid = 0; out_ready = 1;
    while (q.size() > 0) begin
      vectors++; if (out_data !== q[0].word) begin miscompares++; $display("FAIL flush_data got %h exp %h", out_data, q[0].word); end
      tick();
    end
    out_ready = 0;
  endtask

  task automatic test_alarm_tag();
    clr_alarm = 1; tick(); clr_alarm = 0;
    in_valid = 1; sum_in = 4'h6; alarm_in = 1; tick();
    sum_in = 4'h7; alarm_in = 0; tick();
    in_valid = 0;
    vectors++; if (out_data !== q[0].word || out_alarm !== q[0].tag || out_alarm !== 1'b1) begin
      miscompares++; $display("FAIL tag1 got %h/%b exp 6/1", out_data, out_alarm); end
    vectors++; if (alarm_sticky !== exp_sticky || alarm_count !== exp_cnt || alarm_count !== 8'd1) begin
      miscompares++; $display("FAIL alarm_acc got %b/%0d exp 1/1", alarm_sticky, alarm_count); end
    out_ready = 1; tick();
    vectors++; if (out_data !== 4'h7 || out_alarm !== 1'b0) begin miscompares++; $display("FAIL tag0 got %h/%b exp 7/0", out_data, out_alarm); end
    tick(); out_ready = 0;
  endtask

  task automatic test_parity();
    apply_reset();
    for (int i = 0; i < 3; i++) begin in_valid = 1; sum_in = 4'(3 * i + 5); tick(); end
    in_valid = 0;
    vectors++; if (out_par_err !== 1'b0) begin miscompares++; $display("FAIL par_clean got %b exp 0", out_par_err); end
    dut.mem_word[0][1] = ~dut.mem_word[0][1];
    #1;
    vectors++; if (out_par_err !== 1'b1 || out_data !== (q[0].word ^ 4'b0010)) begin
      miscompares++; $display("FAIL par_upset got %b/%h exp 1/%h", out_par_err, out_data, q[0].word ^ 4'b0010); end
    out_ready = 1; tick();
    for (int i = 0; i < 2; i++) begin
      vectors++; if (out_par_err !== 1'b0 || out_data !== q[0].word) begin
        miscompares++; $display("FAIL par_other%0d got %b/%h exp 0/%h", i, out_par_err, out_data, q[0].word); end
      tick();
    end
    out_ready = 0;
  endtask

  task automatic test_counter();
    clr_alarm = 1; alarm_in = 0; tick(); clr_alarm = 0;
    vectors++; if (alarm_count !== 8'd0 || d2_alarm_count !== 2'd0 || alarm_sticky !== 1'b0) begin
      miscompares++; $display("FAIL cnt_clear got %0d/%0d/%b exp 0/0/0", alarm_count, d2_alarm_count, alarm_sticky); end
    alarm_in = 1;
    for (int i = 0; i < 5; i++) tick();
    alarm_in = 0;
    vectors++; if (d2_alarm_count !== exp_cnt2 || d2_alarm_count !== 2'd3) begin miscompares++; $display("FAIL cnt_sat got %0d exp 3", d2_alarm_count); end
    vectors++; if (alarm_count !== exp_cnt || alarm_count !== 8'd5 || d2_alarm_sticky !== 1'b1) begin
      miscompares++; $display("FAIL cnt_wide got %0d/%b exp 5/1", alarm_count, d2_alarm_sticky); end
    tick();
    vectors++; if (d2_alarm_count !== 2'd3) begin miscompares++; $display("FAIL cnt_hold got %0d exp 3", d2_alarm_count); end
    clr_alarm = 1; alarm_in = 1; tick();
    vectors++; if (alarm_count !== 8'd1 || d2_alarm_count !== 2'd1 || alarm_sticky !== 1'b1 || d2_alarm_sticky !== 1'b1) begin
      miscompares++; $display("FAIL clr_vs_alarm got %0d/%0d/%b exp 1/1/1", alarm_count, d2_alarm_count, alarm_sticky); end
    alarm_in = 0; tick(); clr_alarm = 0;
    vectors++; if (alarm_count !== exp_cnt || alarm_count !== 8'd0 || alarm_sticky !== 1'b0) begin
      miscompares++; $display("FAIL clr_only got %0d/%b exp 0/0", alarm_count, alarm_sticky); end
  endtask

  initial begin
    model_reset();
    last_wr = 0;
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_alarm_tag();
    test_parity();
    test_counter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
